// File: rtl/i2c_ctrl_pkg.sv
// Shared definitions for the I2C master arbiter: FSM state encoding,
// default timing parameters and the I2C field widths.
// No ports (package).
package i2c_ctrl_pkg;
    localparam int I2C_ADDR_W     = 7;
    localparam int I2C_DATA_W     = 8;
    localparam int DEF_START_HOLD = 1000;
    localparam int DEF_TIMEOUT    = 200000;
    localparam int DEF_CNT_W      = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;
endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - index that has highest priority this round
//   grant_o - index of the first set request at or after ptr_i (wrapping)
//   any_o   - at least one request is set
module i2c_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   grant_o,
    output logic               any_o
);
    // Scan from the farthest offset down to offset 0 so the closest
    // requester to the pointer is the last (winning) assignment.
    always_comb begin
        grant_o = '0;
        any_o   = |req_i;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
                grant_o = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master between NUM_REQ requesters with round-robin
// arbitration. Latches the winner's command, pulses mast_start_bit for
// START_HOLD cycles, waits for the master's (synchronized) done edge or a
// timeout, then returns read data / error to the winner.
// Ports:
//   fpga_clk, mast_rst              - clock, async active-high reset
//   req_valid/rd_wr/addr/data       - requester command inputs
//   req_ack, resp_valid             - one-hot 1-cycle pulses to requesters
//   resp_data, resp_err             - response payload (held until next response)
//   busy                            - arbiter not idle
//   mast_start_bit/rd_wr/address/data - command to the I2C master
//   data_from_slave, mast_done, mast_nack - status from the I2C master (SCL domain)
module i2c_master_arbiter
    import i2c_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int START_HOLD = DEF_START_HOLD,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                         fpga_clk,
    input  logic                         mast_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_rd_wr,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [I2C_DATA_W-1:0]        resp_data,
    output logic                         resp_err,
    output logic                         busy,
    output logic                         mast_start_bit,
    output logic                         mast_rd_wr,
    output logic [I2C_ADDR_W-1:0]        mast_address,
    output logic [I2C_DATA_W-1:0]        mast_data,
    input  logic [I2C_DATA_W-1:0]        data_from_slave,
    input  logic                         mast_done,
    input  logic                         mast_nack
);
    localparam int PTR_W = $clog2(NUM_REQ);

    state_e                  state_q;
    logic [PTR_W-1:0]        ptr_q, gnt_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_pend_q;
    logic [2:0]              done_sync_q;   // [1:0] synchronizer, [2] edge history
    logic [1:0]              nack_sync_q;
    logic [NUM_REQ-1:0]      req_ack_q, resp_valid_q;
    logic [I2C_DATA_W-1:0]   resp_data_q, mast_data_q;
    logic [I2C_ADDR_W-1:0]   mast_address_q;
    logic                    resp_err_q, mast_start_q, mast_rd_wr_q;

    logic [PTR_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    sel_rd;
    logic [I2C_ADDR_W-1:0]   sel_addr;
    logic [I2C_DATA_W-1:0]   sel_data;
    logic                    done_rise, nack_s;

    i2c_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        sel_rd   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == pick_idx) begin
                sel_rd   = req_rd_wr[i];
                sel_addr = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
                sel_data = req_data[i*I2C_DATA_W +: I2C_DATA_W];
            end
        end
    end

    assign done_rise = done_sync_q[1] & ~done_sync_q[2];
    assign nack_s    = nack_sync_q[1];
    // Saturating: a stuck transaction must never wrap back below TIMEOUT.
    assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge fpga_clk or posedge mast_rst) begin
        if (mast_rst) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            gnt_q          <= '0;
            cnt_q          <= '0;
            done_pend_q    <= 1'b0;
            done_sync_q    <= '0;
            nack_sync_q    <= '0;
            req_ack_q      <= '0;
            resp_valid_q   <= '0;
            resp_data_q    <= '0;
            resp_err_q     <= 1'b0;
            mast_start_q   <= 1'b0;
            mast_rd_wr_q   <= 1'b0;
            mast_address_q <= '0;
            mast_data_q    <= '0;
        end else begin
            done_sync_q  <= {done_sync_q[1:0], mast_done};
            nack_sync_q  <= {nack_sync_q[0], mast_nack};
            req_ack_q    <= '0;
            resp_valid_q <= '0;
            cnt_q        <= cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q             <= ST_ISSUE;
                        gnt_q               <= pick_idx;
                        req_ack_q[pick_idx] <= 1'b1;
                        mast_rd_wr_q        <= sel_rd;
                        mast_address_q      <= sel_addr;
                        mast_data_q         <= sel_data;
                        mast_start_q        <= 1'b1;
                        cnt_q               <= '0;
                        done_pend_q         <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    // A fast master may finish while start is still held.
                    if (done_rise) begin
                        done_pend_q <= 1'b1;
                    end
                    if (cnt_q == CNT_W'(START_HOLD - 1)) begin
                        mast_start_q <= 1'b0;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Done is checked first so it wins over a coincident timeout.
                    if (done_rise || done_pend_q) begin
                        resp_err_q          <= nack_s;
                        resp_data_q         <= (mast_rd_wr_q && !nack_s) ? data_from_slave : '0;
                        resp_valid_q[gnt_q] <= 1'b1;
                        state_q             <= ST_RESP;
                    end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
                        resp_err_q          <= 1'b1;
                        resp_data_q         <= '0;
                        resp_valid_q[gnt_q] <= 1'b1;
                        state_q             <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ptr_q   <= (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ack        = req_ack_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_err       = resp_err_q;
    assign busy           = (state_q != ST_IDLE);
    assign mast_start_bit = mast_start_q;
    assign mast_rd_wr     = mast_rd_wr_q;
    assign mast_address   = mast_address_q;
    assign mast_data      = mast_data_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter with a behavioural I2C master model.
module tb_i2c_master_arbiter;
    localparam int NR = 4;
    localparam int SH = 20;
    localparam int TO = 300;
    localparam int CW = 10;

    logic            fpga_clk = 1'b0;
    logic            mast_rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_rd_wr = '0;
    logic [7*NR-1:0] req_addr = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_ack, resp_valid;
    logic [7:0]      resp_data;
    logic            resp_err, busy, mast_start_bit, mast_rd_wr;
    logic [6:0]      mast_address;
    logic [7:0]      mast_data;
    logic [7:0]      data_from_slave = '0;
    logic            mast_done = 1'b0;
    logic            mast_nack = 1'b0;

    i2c_master_arbiter #(.NUM_REQ(NR), .START_HOLD(SH), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .fpga_clk(fpga_clk), .mast_rst(mast_rst),
        .req_valid(req_valid), .req_rd_wr(req_rd_wr), .req_addr(req_addr), .req_data(req_data),
        .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy), .mast_start_bit(mast_start_bit), .mast_rd_wr(mast_rd_wr),
        .mast_address(mast_address), .mast_data(mast_data),
        .data_from_slave(data_from_slave), .mast_done(mast_done), .mast_nack(mast_nack)
    );

    always #5 fpga_clk = ~fpga_clk;

    int cyc = 0;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    typedef struct { int idx; logic [6:0] addr; logic [7:0] data; logic rd; } ack_t;
    typedef struct { int idx; logic [7:0] data; logic err; int lat; } resp_t;
    ack_t  ack_q[$];
    resp_t resp_q[$];

    int checks = 0, errors = 0;
    int ack_seen = 0, resp_seen = 0, exp_acks = 0, exp_resps = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Master model configuration, set by the stimulus before each request.
    int         m_delay = 40;
    logic       m_never = 1'b0;
    logic       m_nack  = 1'b0;
    logic [7:0] m_data  = 8'h00;

    // Behavioural master: clears its flags on start, raises done after m_delay clocks.
    initial forever begin
        @(posedge mast_start_bit);
        mast_done = 1'b0;
        mast_nack = 1'b0;
        if (!m_never) begin
            repeat (m_delay) @(posedge fpga_clk);
            #2;
            data_from_slave = m_data;
            mast_nack       = m_nack;
            mast_done       = 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an ack or response.
    ack_t  a_e;
    resp_t r_e;
    int    start_cyc = 0, hold_cnt = 0;
    logic  start_prev = 1'b0;
    initial forever begin
        @(negedge fpga_clk);
        if (mast_rst) begin
            hold_cnt   = 0;
            start_prev = 1'b0;
        end else begin
            if (mast_start_bit && !start_prev) start_cyc = cyc;
            if (mast_start_bit) hold_cnt++;
            else if (start_prev) begin
                check("start_hold_cycles", hold_cnt, SH);
                hold_cnt = 0;
            end
            start_prev = mast_start_bit;
            if (req_ack != '0) begin
                ack_seen++;
                if (ack_q.size() == 0) check("unexpected_ack", req_ack, 0);
                else begin
                    a_e = ack_q.pop_front();
                    check("ack_onehot", req_ack, 64'(1) << a_e.idx);
                    check("mast_address", mast_address, a_e.addr);
                    check("mast_data", mast_data, a_e.data);
                    check("mast_rd_wr", mast_rd_wr, a_e.rd);
                    check("start_at_ack", mast_start_bit, 1);
                end
            end
            if (resp_valid != '0) begin
                resp_seen++;
                if (resp_q.size() == 0) check("unexpected_resp", resp_valid, 0);
                else begin
                    r_e = resp_q.pop_front();
                    check("resp_onehot", resp_valid, 64'(1) << r_e.idx);
                    check("resp_data", resp_data, r_e.data);
                    check("resp_err", resp_err, r_e.err);
                    check("busy_in_resp", busy, 1);
                    if (r_e.lat >= 0) check("resp_latency", cyc - start_cyc, r_e.lat);
                end
            end
        end
    end

    task automatic expect_ack(int i, logic rd, logic [6:0] a, logic [7:0] d);
        ack_t e;
        e.idx = i; e.addr = a; e.data = d; e.rd = rd;
        ack_q.push_back(e);
        exp_acks++;
    endtask

    task automatic expect_resp(int i, logic [7:0] d, logic err, int lat);
        resp_t e;
        e.idx = i; e.data = d; e.err = err; e.lat = lat;
        resp_q.push_back(e);
        exp_resps++;
    endtask

    task automatic set_req(int i, logic rd, logic [6:0] a, logic [7:0] d);
        req_rd_wr[i]       = rd;
        req_addr[7*i +: 7] = a;
        req_data[8*i +: 8] = d;
        req_valid[i]       = 1'b1;
    endtask

    task automatic wait_acks(int n, string name);
        int k = 0;
        while (ack_seen < n && k < 3000) begin
            @(negedge fpga_clk); #1; k++;
        end
        if (ack_seen < n) check({name, "_ack_timeout"}, ack_seen, n);
    endtask

    task automatic wait_resps(int n, string name);
        int k = 0;
        while (resp_seen < n && k < 3000) begin
            @(negedge fpga_clk); #1; k++;
        end
        if (resp_seen < n) check({name, "_resp_timeout"}, resp_seen, n);
    endtask

    task automatic single(string name, int i, logic rd, logic [6:0] a, logic [7:0] d,
                          logic [7:0] rdat, logic err, int lat);
        expect_ack(i, rd, a, d);
        expect_resp(i, rdat, err, lat);
        @(negedge fpga_clk);
        set_req(i, rd, a, d);
        wait_acks(exp_acks, name);
        req_valid[i] = 1'b0;
        wait_resps(exp_resps, name);
        repeat (3) @(negedge fpga_clk);
    endtask

    function automatic logic [63:0] all_outs();
        return {29'd0, req_ack, resp_valid, resp_data, resp_err, busy,
                mast_start_bit, mast_rd_wr, mast_address, mast_data};
    endfunction

    initial begin
        repeat (3) @(negedge fpga_clk);
        check("reset_outputs", all_outs(), 0);
        mast_rst = 1'b0;
        repeat (2) @(negedge fpga_clk);
        check("idle_not_busy", busy, 0);

        // Fairness: all four held high, grants must rotate 0,1,2,3,0,1,2,3.
        m_never = 1'b0; m_nack = 1'b0; m_delay = 40; m_data = 8'hEE;
        for (int k = 0; k < 8; k++) begin
            expect_ack(k % NR, 1'b0, 7'(8'h10 + k % NR), 8'(8'h20 + k % NR));
            expect_resp(k % NR, 8'h00, 1'b0, -1);
        end
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 7'(8'h10 + i), 8'(8'h20 + i));
        wait_acks(exp_acks, "fairness");
        req_valid = '0;
        wait_resps(exp_resps, "fairness");
        repeat (3) @(negedge fpga_clk);

        // Single write (master finish time scaled down to 40 clocks).
        single("write", 1, 1'b0, 7'h50, 8'hA5, 8'h00, 1'b0, -1);

        // Read from requester 2.
        m_data = 8'h7E;
        single("read", 2, 1'b1, 7'h3C, 8'h00, 8'h7E, 1'b0, -1);

        // NACK on a read: error, data forced to zero; pointer moves to 1.
        m_nack = 1'b1; m_data = 8'h99;
        single("nack", 0, 1'b1, 7'h22, 8'h00, 8'h00, 1'b1, -1);
        m_nack = 1'b0;

        // Pointer at 1: requesters 0 and 1 together -> 1 first, then 0.
        expect_ack(1, 1'b0, 7'h31, 8'h41); expect_resp(1, 8'h00, 1'b0, -1);
        expect_ack(0, 1'b0, 7'h30, 8'h40); expect_resp(0, 8'h00, 1'b0, -1);
        @(negedge fpga_clk);
        set_req(0, 1'b0, 7'h30, 8'h40);
        set_req(1, 1'b0, 7'h31, 8'h41);
        wait_acks(exp_acks - 1, "ptr_after_nack");
        req_valid[1] = 1'b0;
        wait_acks(exp_acks, "ptr_after_nack");
        req_valid[0] = 1'b0;
        wait_resps(exp_resps, "ptr_after_nack");
        repeat (3) @(negedge fpga_clk);

        // Done arriving while start is still held is honoured at WAIT entry.
        m_delay = 5; m_data = 8'h5A;
        single("early_done", 3, 1'b1, 7'h44, 8'h00, 8'h5A, 1'b0, -1);
        m_delay = 40;

        // Timeout: master never answers; response exactly TO cycles after start.
        m_never = 1'b1;
        single("timeout", 2, 1'b0, 7'h12, 8'h34, 8'h00, 1'b1, TO);
        m_never = 1'b0;

        // Normal grant after the timeout.
        m_data = 8'hC3;
        single("after_timeout", 1, 1'b1, 7'h6B, 8'h00, 8'hC3, 1'b0, -1);

        // Reset while waiting on the master: no response may follow.
        m_never = 1'b1;
        expect_ack(0, 1'b0, 7'h11, 8'h22);
        @(negedge fpga_clk);
        set_req(0, 1'b0, 7'h11, 8'h22);
        wait_acks(exp_acks, "rst_wait");
        req_valid[0] = 1'b0;
        repeat (SH + 10) @(negedge fpga_clk);
        check("in_wait_busy", busy, 1);
        #2 mast_rst = 1'b1;
        #1 check("reset_mid_wait_outputs", all_outs(), 0);
        repeat (3) @(negedge fpga_clk);
        mast_rst = 1'b0;
        m_never = 1'b0;
        repeat (50) @(negedge fpga_clk);

        // Pointer restarted at 0: requesters 1 and 3 together -> 1 then 3.
        m_data = 8'h00;
        expect_ack(1, 1'b0, 7'h51, 8'h61); expect_resp(1, 8'h00, 1'b0, -1);
        expect_ack(3, 1'b0, 7'h53, 8'h63); expect_resp(3, 8'h00, 1'b0, -1);
        set_req(1, 1'b0, 7'h51, 8'h61);
        set_req(3, 1'b0, 7'h53, 8'h63);
        wait_acks(exp_acks - 1, "after_reset");
        req_valid[1] = 1'b0;
        wait_acks(exp_acks, "after_reset");
        req_valid[3] = 1'b0;
        wait_resps(exp_resps, "after_reset");

        repeat (20) @(negedge fpga_clk);
        check("ack_queue_drained", ack_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
